// File: rtl/onboard_input_conditioner_if.sv
// Raw pin inputs and conditioned outputs of the onboard input conditioner.
// master: the harness or bench side; slave: the conditioner itself.
interface onboard_input_conditioner_if #(
    parameter int NUM_BUTTONS  = 2,
    parameter int SWITCH_WIDTH = 4
);
    logic [NUM_BUTTONS-1:0]  BUTTON;
    logic [SWITCH_WIDTH-1:0] SWITCH;
    logic [NUM_BUTTONS-1:0]  BUTTON_LEVEL;
    logic [NUM_BUTTONS-1:0]  BUTTON_PRESS;
    logic [NUM_BUTTONS-1:0]  BUTTON_RELEASE;
    logic [SWITCH_WIDTH-1:0] SWITCH_STABLE;
    logic                    SWITCH_CHANGE;

    modport master (
        output BUTTON, SWITCH,
        input  BUTTON_LEVEL, BUTTON_PRESS, BUTTON_RELEASE, SWITCH_STABLE, SWITCH_CHANGE
    );

    modport slave (
        input  BUTTON, SWITCH,
        output BUTTON_LEVEL, BUTTON_PRESS, BUTTON_RELEASE, SWITCH_STABLE, SWITCH_CHANGE
    );
endinterface

// File: rtl/onboard_input_conditioner.sv
// Synchronizes and debounces active-low buttons and a switch bank into clean levels and pulses.
// Define HOLD_REPEAT_EN to build per-button auto-repeat of BUTTON_PRESS while a button is held.
module onboard_input_conditioner #(
    parameter int NUM_BUTTONS     = 2,
    parameter int SWITCH_WIDTH    = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic CLK,
    input logic RESET,
    onboard_input_conditioner_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} btn_state_t;
    typedef enum logic {SW_IDLE, SW_COUNT} sw_state_t;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("onboard_input_conditioner: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

`ifdef HOLD_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
`endif

    // Two-flop synchronizers; buttons are inverted first so 1 means pressed from here on.
    logic [NUM_BUTTONS-1:0]  btn_p0, btn_p1;
    logic [SWITCH_WIDTH-1:0] sw_p0, sw_p1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            btn_p0 <= ~bus.BUTTON;
            btn_p1 <= btn_p0;
            sw_p0  <= bus.SWITCH;
            sw_p1  <= sw_p0;
        end
    end

    logic [NUM_BUTTONS-1:0] level_vec, press_vec, release_vec;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        btn_state_t       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
`ifdef HOLD_REPEAT_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              repeat_q, repeat_d;
        logic              hold_hit;

        // First repeat waits REPEAT_DELAY after the press pulse, later ones REPEAT_PERIOD.
        assign hold_hit = (hold_q == (repeat_q ? PERIOD_LAST : DELAY_LAST));
`endif

        always_ff @(posedge CLK) begin
            if (RESET) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef HOLD_REPEAT_EN
                hold_q    <= '0;
                repeat_q  <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef HOLD_REPEAT_EN
                hold_q    <= hold_d;
                repeat_q  <= repeat_d;
`endif
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef HOLD_REPEAT_EN
            hold_d    = '0;
            repeat_d  = 1'b0;
`endif
            case (state_q)
                RELEASED: begin
                    if (btn_p1[i]) begin
                        state_d = CONFIRM_PRESS;
                        cnt_d   = '0;
                    end
                end
                CONFIRM_PRESS: begin
                    if (!btn_p1[i]) begin
                        state_d = RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_p1[i]) begin
                        state_d = CONFIRM_RELEASE;
                        cnt_d   = '0;
                    end
`ifdef HOLD_REPEAT_EN
                    else if (hold_hit) begin
                        press_d  = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        hold_d   = hold_q + HOLD_W'(1);
                        repeat_d = repeat_q;
                    end
`endif
                end
                CONFIRM_RELEASE: begin
                    if (btn_p1[i]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        assign level_vec[i]   = level_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
    end

    // Switch bank: the whole vector must hold one value for D samples before it is accepted.
    sw_state_t               sw_state_q, sw_state_d;
    logic [CNT_W-1:0]        sw_cnt_q, sw_cnt_d;
    logic [SWITCH_WIDTH-1:0] cand_q, cand_d;
    logic [SWITCH_WIDTH-1:0] stable_q, stable_d;
    logic                    change_q, change_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_state_q <= SW_IDLE;
            sw_cnt_q   <= '0;
            stable_q   <= '0;
            change_q   <= 1'b0;
        end else begin
            sw_state_q <= sw_state_d;
            sw_cnt_q   <= sw_cnt_d;
            stable_q   <= stable_d;
            change_q   <= change_d;
        end
    end

    always_ff @(posedge CLK) begin
        cand_q <= cand_d;
    end

    always_comb begin
        sw_state_d = sw_state_q;
        sw_cnt_d   = sw_cnt_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        change_d   = 1'b0;
        case (sw_state_q)
            SW_IDLE: begin
                if (sw_p1 != stable_q) begin
                    sw_state_d = SW_COUNT;
                    cand_d     = sw_p1;
                    sw_cnt_d   = '0;
                end
            end
            SW_COUNT: begin
                if (sw_p1 == stable_q) begin
                    sw_state_d = SW_IDLE;
                end else if (sw_p1 != cand_q) begin
                    cand_d   = sw_p1;
                    sw_cnt_d = '0;
                end else if (sw_cnt_q == CNT_LAST) begin
                    sw_state_d = SW_IDLE;
                    stable_d   = cand_q;
                    change_d   = 1'b1;
                end else begin
                    sw_cnt_d = sw_cnt_q + CNT_W'(1);
                end
            end
            default: sw_state_d = SW_IDLE;
        endcase
    end

    assign bus.BUTTON_LEVEL   = level_vec;
    assign bus.BUTTON_PRESS   = press_vec;
    assign bus.BUTTON_RELEASE = release_vec;
    assign bus.SWITCH_STABLE  = stable_q;
    assign bus.SWITCH_CHANGE  = change_q;
endmodule

// File: tb/tb_onboard_input_conditioner.sv
// Scoreboard bench for onboard_input_conditioner with D=4; expected pulses are queued when
// stimulus is applied and matched cycle-exactly against every pulse the DUT emits.
module tb_onboard_input_conditioner;
    localparam int NB  = 2;
    localparam int SW  = 4;
    localparam int D   = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = D + 3;

    typedef struct {
        int           cyc;
        logic [1:0]   press;
        logic [1:0]   rel;
        logic         chg;
        logic [1:0]   level;
        logic [3:0]   stable;
    } ev_t;

    logic CLK;
    logic RESET;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    ev_t  q[$];
    ev_t  mon_ev;

    onboard_input_conditioner_if #(.NUM_BUTTONS(NB), .SWITCH_WIDTH(SW)) bus ();

    onboard_input_conditioner #(
        .NUM_BUTTONS(NB),
        .SWITCH_WIDTH(SW),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r,
                           input logic ch, input logic [1:0] l, input logic [3:0] s);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.chg = ch; e.level = l; e.stable = s;
        q.push_back(e);
    endtask

    // Scoreboard: every pulse must match the oldest queued event, and no event may be skipped.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: no pulse seen at cycle %0d (now %0d), required press=%b release=%b change=%b",
                         q[0].cyc, cyc, q[0].press, q[0].rel, q[0].chg);
                void'(q.pop_front());
            end
            if ((bus.BUTTON_PRESS | bus.BUTTON_RELEASE) != 2'b00 || bus.SWITCH_CHANGE) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: cycle %0d press=%b release=%b change=%b, required no pulse",
                             cyc, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_CHANGE);
                end else begin
                    mon_ev = q.pop_front();
                    if (cyc !== mon_ev.cyc || bus.BUTTON_PRESS !== mon_ev.press ||
                        bus.BUTTON_RELEASE !== mon_ev.rel || bus.SWITCH_CHANGE !== mon_ev.chg ||
                        bus.BUTTON_LEVEL !== mon_ev.level || bus.SWITCH_STABLE !== mon_ev.stable) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d press=%b rel=%b chg=%b level=%b stable=%b, required cyc=%0d press=%b rel=%b chg=%b level=%b stable=%b",
                                 cyc, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_CHANGE,
                                 bus.BUTTON_LEVEL, bus.SWITCH_STABLE, mon_ev.cyc, mon_ev.press,
                                 mon_ev.rel, mon_ev.chg, mon_ev.level, mon_ev.stable);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        RESET = 1'b1;
        bus.BUTTON = 2'b11;
        bus.SWITCH = 4'b0000;
        repeat (3) @(negedge CLK);
        mon_en = 1'b1;
        n_checks++;
        if ({bus.BUTTON_LEVEL, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_STABLE, bus.SWITCH_CHANGE} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: level=%b press=%b rel=%b stable=%b chg=%b, required all 0",
                     bus.BUTTON_LEVEL, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_STABLE, bus.SWITCH_CHANGE);
        end
        RESET = 1'b0;
        repeat (12) @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_LEVEL !== 2'b00 || bus.SWITCH_STABLE !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: level=%b stable=%b, required 00 / 0000",
                     bus.BUTTON_LEVEL, bus.SWITCH_STABLE);
        end
    endtask

    task automatic test_press();
        int t;
        t = cyc;
        bus.BUTTON[0] = 1'b0;
        push_ev(t + LAT, 2'b01, 2'b00, 1'b0, 2'b01, 4'b0000);
        repeat (LAT - 1) @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_LEVEL !== 2'b00) begin
            n_fail++;
            $display("FAIL press_level_early: cycle %0d level=%b, required 00", cyc - t, bus.BUTTON_LEVEL);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_LEVEL !== 2'b01) begin
            n_fail++;
            $display("FAIL press_level: cycle %0d level=%b, required 01", cyc - t, bus.BUTTON_LEVEL);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_PRESS !== 2'b00 || bus.BUTTON_LEVEL !== 2'b01) begin
            n_fail++;
            $display("FAIL press_one_cycle: press=%b level=%b, required 00 / 01", bus.BUTTON_PRESS, bus.BUTTON_LEVEL);
        end
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL press_drain: %0d events outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_bounce_release();
        int t;
        for (int k = 0; k < 5; k++) begin
            bus.BUTTON[0] = (k % 2 == 1);
            @(negedge CLK);
        end
        bus.BUTTON[0] = 1'b1;
        t = cyc;
        push_ev(t + LAT, 2'b00, 2'b01, 1'b0, 2'b00, 4'b0000);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        n_checks++;
        if (q.size() != 0 || bus.BUTTON_LEVEL !== 2'b00) begin
            n_fail++;
            $display("FAIL bounce_release: outstanding=%0d level=%b, required 0 / 00", q.size(), bus.BUTTON_LEVEL);
            q.delete();
        end
    endtask

    task automatic test_switch();
        int t;
        bus.SWITCH = 4'b0101; @(negedge CLK);
        bus.SWITCH = 4'b0001; @(negedge CLK);
        bus.SWITCH = 4'b0101; @(negedge CLK);
        bus.SWITCH = 4'b0001; @(negedge CLK);
        bus.SWITCH = 4'b0101;
        t = cyc;
        push_ev(t + LAT, 2'b00, 2'b00, 1'b1, 2'b00, 4'b0101);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        n_checks++;
        if (q.size() != 0 || bus.SWITCH_STABLE !== 4'b0101) begin
            n_fail++;
            $display("FAIL switch_accept: outstanding=%0d stable=%b, required 0 / 0101", q.size(), bus.SWITCH_STABLE);
            q.delete();
        end
        // Short excursion away from the stable word and back: must abort silently.
        bus.SWITCH = 4'b0111;
        repeat (2) @(negedge CLK);
        bus.SWITCH = 4'b0101;
        repeat (15) @(negedge CLK);
        n_checks++;
        if (bus.SWITCH_STABLE !== 4'b0101) begin
            n_fail++;
            $display("FAIL switch_abort: stable=%b, required 0101", bus.SWITCH_STABLE);
        end
    endtask

    task automatic test_glitch();
        bus.BUTTON[1] = 1'b0;
        repeat (3) @(negedge CLK);
        bus.BUTTON[1] = 1'b1;
        repeat (15) @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_LEVEL !== 2'b00) begin
            n_fail++;
            $display("FAIL glitch_level: level=%b, required 00", bus.BUTTON_LEVEL);
        end
    endtask

    task automatic test_simultaneous();
        int t;
        t = cyc;
        bus.BUTTON = 2'b00;
        bus.SWITCH = 4'b1010;
        push_ev(t + LAT, 2'b11, 2'b00, 1'b1, 2'b11, 4'b1010);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        t = cyc;
        bus.BUTTON = 2'b11;
        push_ev(t + LAT, 2'b00, 2'b11, 1'b0, 2'b00, 4'b1010);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        n_checks++;
        if (q.size() != 0 || bus.BUTTON_LEVEL !== 2'b00) begin
            n_fail++;
            $display("FAIL simultaneous: outstanding=%0d level=%b, required 0 / 00", q.size(), bus.BUTTON_LEVEL);
            q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int t;
        bus.BUTTON[0] = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({bus.BUTTON_LEVEL, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_STABLE, bus.SWITCH_CHANGE} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: level=%b press=%b rel=%b stable=%b chg=%b, required all 0",
                     bus.BUTTON_LEVEL, bus.BUTTON_PRESS, bus.BUTTON_RELEASE, bus.SWITCH_STABLE, bus.SWITCH_CHANGE);
        end
        RESET = 1'b0;
        t = cyc;
        push_ev(t + LAT, 2'b01, 2'b00, 1'b1, 2'b01, 4'b1010);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        t = cyc;
        bus.BUTTON[0] = 1'b1;
        push_ev(t + LAT, 2'b00, 2'b01, 1'b0, 2'b00, 4'b1010);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        n_checks++;
        if (q.size() != 0 || bus.BUTTON_LEVEL !== 2'b00 || bus.SWITCH_STABLE !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_mid_recover: outstanding=%0d level=%b stable=%b, required 0 / 00 / 1010",
                     q.size(), bus.BUTTON_LEVEL, bus.SWITCH_STABLE);
            q.delete();
        end
    endtask

    task automatic test_hold();
        int t;
        int tr;
        t  = cyc;
        tr = t + 40;
        bus.BUTTON[1] = 1'b0;
        push_ev(t + LAT, 2'b10, 2'b00, 1'b0, 2'b10, 4'b1010);
`ifdef HOLD_REPEAT_EN
        for (int p = t + LAT + RD; p <= tr + 2; p += RP)
            push_ev(p, 2'b10, 2'b00, 1'b0, 2'b10, 4'b1010);
`endif
        repeat (40) @(negedge CLK);
        n_checks++;
        if (bus.BUTTON_LEVEL !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_level: level=%b, required 10", bus.BUTTON_LEVEL);
        end
        bus.BUTTON[1] = 1'b1;
        push_ev(tr + LAT, 2'b00, 2'b10, 1'b0, 2'b00, 4'b1010);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge CLK);
        repeat (20) @(negedge CLK);
        n_checks++;
        if (q.size() != 0 || bus.BUTTON_LEVEL !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_release: outstanding=%0d level=%b, required 0 / 00", q.size(), bus.BUTTON_LEVEL);
            q.delete();
        end
    endtask

    initial begin
        RESET = 1'b1;
        bus.BUTTON = 2'b11;
        bus.SWITCH = 4'b0000;
        test_reset();
        test_press();
        test_bounce_release();
        test_switch();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
